// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin / fixed-priority arbiter with a registered grant.
//
// Two priority encoders resolve the request vector. One sees only the
// requests selected by the rotation mask. The other sees the full request
// vector. In round-robin mode the masked result wins whenever it is nonzero.
// Otherwise the unmasked result is used, which is how the rotation wraps.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   request       in   [PORTS] level-sensitive request vector
//   acknowledge   in   [PORTS] one-cycle release pulse for the granted port
//   grant         out  [PORTS] one-hot grant (registered)
//   grant_valid   out  high when grant is nonzero (registered)
//   grant_encoded out  [ENC_W] index of the granted port (registered)
//
// Handshake: a port holds its request high until it sees its grant bit.
// In blocking mode the grant stays with that port until it is released:
//   - with ack: the port pulses its acknowledge bit for one cycle;
//   - without ack: the port drops its request.
// A new winner is loaded at the releasing edge, so there is no idle gap.

// Priority encoder shared by both arbitration paths.
// LSB_PRIORITY "HIGH": index 0 wins.
// LSB_PRIORITY "LOW": the highest index wins.
module rr_arbiter_prio_enc #(
  parameter int    WIDTH        = 4,
  parameter int    ENC_W        = 2,
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  output logic [ENC_W-1:0] out_index,
  output logic [WIDTH-1:0] out_onehot
);
  localparam bit LSB_HIGH = (LSB_PRIORITY == "HIGH");

  always_comb begin
    out_valid  = |in_bits;
    out_index  = '0;
    out_onehot = '0;
    if (LSB_HIGH) begin
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_bits[i]) begin
          out_index     = ENC_W'(i);
          out_onehot    = '0;
          out_onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_bits[i]) begin
          out_index     = ENC_W'(i);
          out_onehot    = '0;
          out_onehot[i] = 1'b1;
        end
      end
    end
  end
endmodule

module rr_arbiter #(
  parameter int    PORTS                = 4,
  parameter bit    ARB_TYPE_ROUND_ROBIN = 1'b1,
  parameter bit    ARB_BLOCK            = 1'b1,
  parameter bit    ARB_BLOCK_ACK        = 1'b1,
  parameter string LSB_PRIORITY         = "LOW",
  localparam int   ENC_W                = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [ENC_W-1:0] grant_encoded
);
  localparam bit LSB_HIGH = (LSB_PRIORITY == "HIGH");

  logic [PORTS-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [ENC_W-1:0] enc_q, enc_d;
  logic [PORTS-1:0] mask_q, mask_d;

  logic [PORTS-1:0] masked_req;
  logic             m_valid, u_valid;
  logic [ENC_W-1:0] m_index, u_index;
  logic [PORTS-1:0] m_onehot, u_onehot;

  logic [PORTS-1:0] ack_eff;
  logic             hold;
  logic [ENC_W-1:0] win_index;
  logic [PORTS-1:0] win_onehot;
  logic [PORTS-1:0] win_mask;

  assign masked_req = request & mask_q;

  rr_arbiter_prio_enc #(
    .WIDTH       (PORTS),
    .ENC_W       (ENC_W),
    .LSB_PRIORITY(LSB_PRIORITY)
  ) u_enc_masked (
    .in_bits   (masked_req),
    .out_valid (m_valid),
    .out_index (m_index),
    .out_onehot(m_onehot)
  );

  rr_arbiter_prio_enc #(
    .WIDTH       (PORTS),
    .ENC_W       (ENC_W),
    .LSB_PRIORITY(LSB_PRIORITY)
  ) u_enc_unmasked (
    .in_bits   (request),
    .out_valid (u_valid),
    .out_index (u_index),
    .out_onehot(u_onehot)
  );

  // The current owner keeps the grant while it still requests. In ack mode
  // it must also not be acknowledging. Acknowledge bits of other ports fall
  // away through the AND with grant_q.
  always_comb begin
    ack_eff = ARB_BLOCK_ACK ? acknowledge : '0;
    hold    = ARB_BLOCK && (|(grant_q & request & ~ack_eff));
  end

  // Winner selection and the rotation mask that the winner would install.
  always_comb begin
    win_index  = u_index;
    win_onehot = u_onehot;
    if (ARB_TYPE_ROUND_ROBIN && m_valid) begin
      win_index  = m_index;
      win_onehot = m_onehot;
    end
    win_mask = '0;
    // Mask out the winner and every port that ranks ahead of it. Ports
    // that rank behind the winner get first chance next time.
    for (int j = 0; j < PORTS; j++) begin
      if (LSB_HIGH) win_mask[j] = (j > int'(win_index));
      else          win_mask[j] = (j < int'(win_index));
    end
  end

  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    enc_d   = enc_q;
    mask_d  = mask_q;
    if (!hold) begin
      if (u_valid) begin
        grant_d = win_onehot;
        valid_d = 1'b1;
        enc_d   = win_index;
        if (ARB_TYPE_ROUND_ROBIN) mask_d = win_mask;
      end else begin
        // Nobody is asking. Keep the last index so software can still
        // see which port owned the grant most recently.
        grant_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      enc_q   <= '0;
      mask_q  <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      enc_q   <= enc_d;
      mask_q  <= mask_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = valid_q;
  assign grant_encoded = enc_q;

  // Output invariants: zero-or-one-hot grant, and a consistent valid bit
  // and index.
  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant_q));
  a_valid_matches : assert property (@(posedge clk) valid_q == (|grant_q));
  a_enc_matches   : assert property (@(posedge clk)
    valid_q |-> (grant_q == (PORTS'(1) << enc_q)));
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter.
//
// Five configurations run side by side on a shared clock, reset and request
// bus. Each step names the instance whose output it checks.
//
// The driver applies inputs just after a falling edge. It also pushes the
// hand-computed result expected at the next rising edge. The monitor pops
// one entry per falling edge and compares it with the named instance.
//
// Instance IDs:
//   0 rr_ack    round-robin, HIGH, block, release on ack
//   1 rr_free   round-robin, HIGH, no block
//   2 rr_noack  round-robin, HIGH, block, release on request drop
//   3 fp_low    fixed priority, LOW, no block
//   4 fp_high   fixed priority, HIGH, no block
module tb_rr_arbiter;
  logic       clk;
  logic       rst;
  logic [3:0] request;
  logic [3:0] acknowledge;

  logic [3:0] g0, g1, g2, g3, g4;
  logic       v0, v1, v2, v3, v4;
  logic [1:0] e0, e1, e2, e3, e4;

  // Entry layout: {id[2:0], valid, enc[1:0], grant[3:0]}
  logic [9:0] exp_q[$];
  string      name_q[$];
  int         tests_run;
  int         tests_failed;

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .ARB_BLOCK(1'b1),
    .ARB_BLOCK_ACK(1'b1), .LSB_PRIORITY("HIGH")) u_rr_ack (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g0), .grant_valid(v0), .grant_encoded(e0));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .ARB_BLOCK(1'b0),
    .ARB_BLOCK_ACK(1'b1), .LSB_PRIORITY("HIGH")) u_rr_free (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g1), .grant_valid(v1), .grant_encoded(e1));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .ARB_BLOCK(1'b1),
    .ARB_BLOCK_ACK(1'b0), .LSB_PRIORITY("HIGH")) u_rr_noack (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g2), .grant_valid(v2), .grant_encoded(e2));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b0), .ARB_BLOCK(1'b0),
    .ARB_BLOCK_ACK(1'b0), .LSB_PRIORITY("LOW")) u_fp_low (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g3), .grant_valid(v3), .grant_encoded(e3));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b0), .ARB_BLOCK(1'b0),
    .ARB_BLOCK_ACK(1'b0), .LSB_PRIORITY("HIGH")) u_fp_high (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g4), .grant_valid(v4), .grant_encoded(e4));

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst         = 1'b1;
    request     = '0;
    acknowledge = '0;
  end

  // Driver: one call per clock cycle.
  task automatic step(input int id, input logic r, input logic [3:0] req,
                      input logic [3:0] ack, input logic [3:0] eg,
                      input logic [1:0] ee, input string nm);
    logic [2:0] id3;
    @(negedge clk);
    #1;
    id3         = id[2:0];
    rst         = r;
    request     = req;
    acknowledge = ack;
    exp_q.push_back({id3, |eg, ee, eg});
    name_q.push_back(nm);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      logic [6:0] act;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e[9:7])
        3'd0:    act = {v0, e0, g0};
        3'd1:    act = {v1, e1, g1};
        3'd2:    act = {v2, e2, g2};
        3'd3:    act = {v3, e3, g3};
        default: act = {v4, e4, g4};
      endcase
      tests_run++;
      if (act !== e[6:0]) begin
        tests_failed++;
        $display("FAIL %s dut%0d: got valid=%b enc=%0d grant=%b, want valid=%b enc=%0d grant=%b",
                 nm, e[9:7], act[6], act[5:4], act[3:0], e[6], e[5:4], e[3:0]);
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset held with all requests up, then rotation from index 0.
    repeat (3) step(1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, "rst_hold");
    step(1, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, "first_grant");
    step(1, 1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, "rr_rot1");
    step(1, 1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, "rr_rot2");
    step(1, 1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, "rr_rot3");
    step(1, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, "rr_wrap0");
    step(1, 1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, "rr_wrap1");

    // Blocking with acknowledge.
    step(0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "rst");
    step(0, 1'b0, 4'b0110, 4'b0000, 4'b0010, 2'd1, "blk_grant");
    repeat (5) step(0, 1'b0, 4'b0110, 4'b0000, 4'b0010, 2'd1, "blk_hold");
    step(0, 1'b0, 4'b0110, 4'b0010, 4'b0100, 2'd2, "ack_handoff");
    step(0, 1'b0, 4'b0110, 4'b0000, 4'b0100, 2'd2, "blk_hold2");
    step(0, 1'b0, 4'b0110, 4'b0010, 4'b0100, 2'd2, "ack_nongranted");
    step(0, 1'b0, 4'b0110, 4'b0100, 4'b0010, 2'd1, "ack_wrap");
    step(0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, "idle_keep_enc");
    step(0, 1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, "regrant");
    step(0, 1'b0, 4'b0011, 4'b0010, 4'b0001, 2'd0, "release_to_0");
    step(0, 1'b0, 4'b0011, 4'b0001, 4'b0010, 2'd1, "rerequest_loses");

    // Blocking without acknowledge: acknowledge has no effect.
    step(2, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "rst");
    step(2, 1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, "noack_grant");
    step(2, 1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, "noack_ack_ignored");
    step(2, 1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, "noack_drop");
    step(2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd3, "noack_idle");

    // Fixed priority, both encoder orientations.
    step(3, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "rst");
    repeat (3) step(3, 1'b0, 4'b1010, 4'b0000, 4'b1000, 2'd3, "fp_low");
    step(4, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "rst");
    repeat (2) step(4, 1'b0, 4'b1010, 4'b0000, 4'b0010, 2'd1, "fp_high");
    step(4, 1'b0, 4'b1010, 4'b0010, 4'b0010, 2'd1, "fp_high_ack");

    // Reset in the middle of a hold clears the mask.
    step(0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "rst");
    step(0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, "mid_grant");
    repeat (2) step(0, 1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, "mid_hold");
    step(0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, "mid_rst");
    step(0, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, "post_rst_fresh");

    // Drain the last expectation.
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
